// File: rtl/grid_pkg.sv
// grid_walker shared definitions: cell codes, command codes, FSM states.
// Imported by grid_walker and grid_reveal_scan.
package grid_pkg;

    localparam logic [2:0] CELL_UNKNOWN  = 3'd0;
    localparam logic [2:0] CELL_CURRENT  = 3'd1;
    localparam logic [2:0] CELL_ENTRANCE = 3'd2;
    localparam logic [2:0] CELL_EXIT     = 3'd3;
    localparam logic [2:0] CELL_BLANK    = 3'd4;
    localparam logic [2:0] CELL_WALL     = 3'd5;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_RIGHT = 3'd1;
    localparam logic [2:0] CMD_LEFT  = 3'd2;
    localparam logic [2:0] CMD_UP    = 3'd3;
    localparam logic [2:0] CMD_DOWN  = 3'd4;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_MOVE   = 2'd2,
        ST_REVEAL = 2'd3
    } state_t;

endpackage

// File: rtl/grid_reveal_scan.sv
// Fog-reveal window scanner: walks the (2R+1)^2 offsets row-major from
// (-R,-R) around pos, one per cycle while en is high.
// Ports: clk, rst, en (scan running), pos_x/pos_y (window centre),
//        cell_x/cell_y (current cell), hit (in grid and within Manhattan
//        radius), last (final offset of the window).
module grid_reveal_scan
    import grid_pkg::*;
#(
    parameter int MAP_W    = 10,
    parameter int MAP_H    = 10,
    parameter int REVEAL_R = 2,
    parameter int XW       = 4,
    parameter int YW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [XW-1:0] pos_x,
    input  logic [YW-1:0] pos_y,
    output logic [XW-1:0] cell_x,
    output logic [YW-1:0] cell_y,
    output logic          hit,
    output logic          last
);

    localparam int SPAN = 2 * REVEAL_R + 1;
    localparam int OW   = $clog2(SPAN + 1);
    localparam logic [OW-1:0] OFF_MAX = OW'(SPAN - 1);

    logic [OW-1:0] col_q;
    logic [OW-1:0] row_q;

    // Counter idles at the window origin so each REVEAL entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            col_q <= '0;
            row_q <= '0;
        end else if (col_q == OFF_MAX) begin
            col_q <= '0;
            row_q <= (row_q == OFF_MAX) ? '0 : row_q + OW'(1);
        end else begin
            col_q <= col_q + OW'(1);
        end
    end

    int dx, dy, cx, cy, adx, ady;

    always_comb begin
        dx  = int'(col_q) - REVEAL_R;
        dy  = int'(row_q) - REVEAL_R;
        cx  = int'(pos_x) + dx;
        cy  = int'(pos_y) + dy;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        hit = (cx >= 0) && (cx < MAP_W) &&
              (cy >= 0) && (cy < MAP_H) &&
              (adx + ady <= REVEAL_R);
        cell_x = XW'(cx);
        cell_y = YW'(cy);
        last   = (col_q == OFF_MAX) && (row_q == OFF_MAX);
    end

endmodule

// File: rtl/grid_walker.sv
// Grid walker: moves a cursor over a MAP_W x MAP_H cell map, refusing
// off-grid and WALL moves, and reveals fog around it after each command.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd/cmd_ready command
//        handshake; wr_en/wr_addr/wr_data map write; rd_addr -> rd_data,
//        rd_vis (1-cycle read); pos_x/pos_y, at_exit, done, blocked.
// Option: GRID_WALKER_STEPCNT_EN adds a saturating 16-bit step_cnt.
module grid_walker
    import grid_pkg::*;
#(
    parameter  int MAP_W    = 10,
    parameter  int MAP_H    = 10,
    parameter  int REVEAL_R = 2,
    parameter  int START_X  = 0,
    parameter  int START_Y  = 5,
    localparam int AW       = $clog2(MAP_W * MAP_H),
    localparam int XW       = $clog2(MAP_W),
    localparam int YW       = $clog2(MAP_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd,
    output logic          cmd_ready,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [2:0]    rd_data,
    output logic          rd_vis,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic          at_exit,
    output logic          done,
    output logic          blocked
`ifdef GRID_WALKER_STEPCNT_EN
    ,
    output logic [15:0]   step_cnt
`endif
);

    localparam int CELLS = MAP_W * MAP_H;
    localparam logic [AW:0]   CELLS_W   = (AW+1)'(CELLS);
    localparam logic [AW-1:0] LAST_IDX  = AW'(CELLS - 1);
    localparam logic [AW-1:0] START_IDX = AW'(START_Y * MAP_W + START_X);
    localparam logic [AW-1:0] EXIT_IDX  = AW'(START_Y * MAP_W + MAP_W - 1);
    localparam logic [XW-1:0] X_MAX     = XW'(MAP_W - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(MAP_H - 1);
    localparam logic [XW-1:0] X_START   = XW'(START_X);
    localparam logic [YW-1:0] Y_START   = YW'(START_Y);

    // Map storage holds each cell XOR its power-up code, so an all-zero
    // array is the default map (BLANK, ENTRANCE at start, EXIT opposite).
    logic [2:0] map_q [CELLS];
    logic       vis_q [CELLS];

    state_t        state;
    logic [AW-1:0] clr_idx;
    logic [2:0]    cmd_q;
    logic          blk_q;
    logic          busy_q;

    function automatic logic [2:0] dflt_code(input logic [AW-1:0] i);
        if (i == START_IDX) return CELL_ENTRANCE;
        if (i == EXIT_IDX)  return CELL_EXIT;
        return CELL_BLANK;
    endfunction

    function automatic logic [2:0] cell_code(input logic [AW-1:0] i);
        return map_q[i] ^ dflt_code(i);
    endfunction

    function automatic logic [AW-1:0] idx_of(input logic [XW-1:0] x,
                                             input logic [YW-1:0] y);
        return AW'(int'(y) * MAP_W + int'(x));
    endfunction

    logic [AW-1:0] pos_idx;
    assign pos_idx = idx_of(pos_x, pos_y);

    // Move target decode.
    logic [XW-1:0] tgt_x;
    logic [YW-1:0] tgt_y;
    logic          off_grid;
    logic          is_move;
    logic          tgt_wall;
    logic          mv_blocked;
    logic          mv_go;

    always_comb begin
        tgt_x    = pos_x;
        tgt_y    = pos_y;
        off_grid = 1'b0;
        is_move  = 1'b1;
        unique case (1'b1)
            (cmd_q == CMD_RIGHT): begin
                if (pos_x == X_MAX) off_grid = 1'b1;
                else                tgt_x = pos_x + XW'(1);
            end
            (cmd_q == CMD_LEFT): begin
                if (pos_x == '0) off_grid = 1'b1;
                else             tgt_x = pos_x - XW'(1);
            end
            (cmd_q == CMD_UP): begin
                if (pos_y == '0) off_grid = 1'b1;
                else             tgt_y = pos_y - YW'(1);
            end
            (cmd_q == CMD_DOWN): begin
                if (pos_y == Y_MAX) off_grid = 1'b1;
                else                tgt_y = pos_y + YW'(1);
            end
            default: is_move = 1'b0;
        endcase
        // Reads the registered map, i.e. before any same-cycle write.
        tgt_wall   = (cell_code(idx_of(tgt_x, tgt_y)) == CELL_WALL);
        mv_blocked = is_move && (off_grid || tgt_wall);
        mv_go      = is_move && !mv_blocked;
    end

    // Reveal window.
    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;
    logic          scan_hit;
    logic          scan_last;
    logic          scan_en;
    logic [AW-1:0] scan_idx;

    assign scan_en  = (state == ST_REVEAL);
    assign scan_idx = idx_of(scan_x, scan_y);

    grid_reveal_scan #(
        .MAP_W    (MAP_W),
        .MAP_H    (MAP_H),
        .REVEAL_R (REVEAL_R),
        .XW       (XW),
        .YW       (YW)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .en     (scan_en),
        .pos_x  (pos_x),
        .pos_y  (pos_y),
        .cell_x (scan_x),
        .cell_y (scan_y),
        .hit    (scan_hit),
        .last   (scan_last)
    );

    // Control FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            pos_x     <= X_START;
            pos_y     <= Y_START;
            cmd_q     <= CMD_NOP;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            blocked   <= 1'b0;
            at_exit   <= 1'b0;
            blk_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done    <= 1'b0;
            blocked <= 1'b0;
            at_exit <= (cell_code(pos_idx) == CELL_EXIT);
            unique case (state)
                ST_CLEAR: begin
                    if (clr_idx == LAST_IDX) state <= ST_REVEAL;
                    else                     clr_idx <= clr_idx + AW'(1);
                end
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_q     <= cmd;
                        cmd_ready <= 1'b0;
                        busy_q    <= 1'b1;
                        blk_q     <= 1'b0;
                        state     <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (mv_blocked) begin
                        blk_q <= 1'b1;
                    end else if (mv_go) begin
                        pos_x <= tgt_x;
                        pos_y <= tgt_y;
                    end
                    state <= ST_REVEAL;
                end
                ST_REVEAL: begin
                    if (scan_last) begin
                        // The post-CLEAR reveal has no command to complete.
                        done      <= busy_q;
                        blocked   <= busy_q & blk_q;
                        busy_q    <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Map, visibility and display read port (contents never reset).
    always_ff @(posedge clk) begin
        if (wr_en && state != ST_CLEAR && ({1'b0, wr_addr} < CELLS_W))
            map_q[wr_addr] <= wr_data ^ dflt_code(wr_addr);
        if (state == ST_CLEAR)
            vis_q[clr_idx] <= 1'b0;
        else if (state == ST_REVEAL && scan_hit)
            vis_q[scan_idx] <= 1'b1;
        if ({1'b0, rd_addr} < CELLS_W) begin
            rd_data <= cell_code(rd_addr);
            rd_vis  <= vis_q[rd_addr] | (rd_addr == pos_idx);
        end else begin
            rd_data <= CELL_UNKNOWN;
            rd_vis  <= 1'b0;
        end
    end

`ifdef GRID_WALKER_STEPCNT_EN
    logic [15:0] step_q;

    always_ff @(posedge clk) begin
        if (rst)
            step_q <= '0;
        else if (state == ST_MOVE && mv_go && step_q != 16'hFFFF)
            step_q <= step_q + 16'd1;
    end

    assign step_cnt = step_q;
`endif

endmodule

// File: tb/tb_grid_walker.sv
// Directed bench for grid_walker at default parameters (10x10, R = 2).
// Covers reset/clear, moves, blocking, exit detection and mid-reveal reset.
module tb_grid_walker;
    import grid_pkg::*;

    localparam int AW = 7;
    localparam int XW = 4;
    localparam int YW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd = '0;
    logic          cmd_ready;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [2:0]    wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [2:0]    rd_data;
    logic          rd_vis;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          at_exit;
    logic          done;
    logic          blocked;
`ifdef GRID_WALKER_STEPCNT_EN
    logic [15:0]   step_cnt;
`endif

    always #5 clk = ~clk;

    grid_walker dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_vis    (rd_vis),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .at_exit   (at_exit),
        .done      (done),
        .blocked   (blocked)
`ifdef GRID_WALKER_STEPCNT_EN
        ,
        .step_cnt  (step_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_ready && n < 400) begin
            tick();
            n++;
        end
    endtask

    // Issue one command; optionally write a map cell on the MOVE cycle.
    task automatic run_cmd(input logic [2:0] c, input logic wr,
                           input int wa, input logic [2:0] wd,
                           output int lat);
        int n;
        wait_ready(n);
        check("cmd_ready_before_cmd", 32'(cmd_ready), 1);
        cmd       = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wr_en     = wr;
        wr_addr   = AW'(wa);
        wr_data   = wd;
        lat       = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            wr_en = 1'b0;
        end
    endtask

    task automatic rd(input int a, output logic [2:0] d, output logic v);
        rd_addr = AW'(a);
        tick();
        d = rd_data;
        v = rd_vis;
    endtask

    int         lat;
    int         n;
    int         dn;
    logic [2:0] d;
    logic       v;
    int         vis_on [9] = '{30, 40, 41, 50, 51, 52, 60, 61, 70};

    initial begin
        // Reset and clear.
        rst = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_blocked", 32'(blocked), 0);
        check("rst_at_exit", 32'(at_exit), 0);
        check("rst_pos_x", 32'(pos_x), 0);
        check("rst_pos_y", 32'(pos_y), 5);
`ifdef GRID_WALKER_STEPCNT_EN
        check("rst_step_cnt", 32'(step_cnt), 0);
`endif
        rst = 1'b0;
        wait_ready(n);
        check("ready_after_clear", n, 125);
        foreach (vis_on[i]) begin
            rd(vis_on[i], d, v);
            check($sformatf("vis_%0d", vis_on[i]), 32'(v), 1);
        end
        rd(53, d, v);
        check("vis_53_hidden", 32'(v), 0);
        rd(50, d, v);
        check("code_entrance", 32'(d), 32'(CELL_ENTRANCE));
        rd(59, d, v);
        check("code_exit", 32'(d), 32'(CELL_EXIT));
        rd(55, d, v);
        check("code_blank", 32'(d), 32'(CELL_BLANK));

        // LEFT off the west edge.
        run_cmd(CMD_LEFT, 1'b0, 0, 3'd0, lat);
        check("left_lat", lat, 26);
        check("left_blocked", 32'(blocked), 1);
        check("left_pos_x", 32'(pos_x), 0);
        tick();
        check("done_one_cycle", 32'(done), 0);

        // WALL to the east, then same-cycle BLANK overwrite still blocks.
        wr_en   = 1'b1;
        wr_addr = AW'(51);
        wr_data = CELL_WALL;
        tick();
        wr_en = 1'b0;
        rd(51, d, v);
        check("code_wall", 32'(d), 32'(CELL_WALL));
        run_cmd(CMD_RIGHT, 1'b0, 0, 3'd0, lat);
        check("wall_blocked", 32'(blocked), 1);
        check("wall_pos_x", 32'(pos_x), 0);
        run_cmd(CMD_RIGHT, 1'b1, 51, CELL_BLANK, lat);
        check("prewrite_lat", lat, 26);
        check("prewrite_blocked", 32'(blocked), 1);
        check("prewrite_pos_x", 32'(pos_x), 0);
        rd(51, d, v);
        check("code_51_blank", 32'(d), 32'(CELL_BLANK));

        // Free RIGHT move.
        run_cmd(CMD_RIGHT, 1'b0, 0, 3'd0, lat);
        check("right_lat", lat, 26);
        check("right_blocked", 32'(blocked), 0);
        check("right_pos_x", 32'(pos_x), 1);
        check("right_pos_y", 32'(pos_y), 5);
        rd(53, d, v);
        check("vis_53_after_right", 32'(v), 1);

        // NOP (code 7) completes without moving.
        run_cmd(3'd7, 1'b0, 0, 3'd0, lat);
        check("nop_lat", lat, 26);
        check("nop_blocked", 32'(blocked), 0);
        check("nop_pos_x", 32'(pos_x), 1);

        // Eight more RIGHT to reach the exit, then no wrap.
        for (int i = 0; i < 8; i++)
            run_cmd(CMD_RIGHT, 1'b0, 0, 3'd0, lat);
        check("exit_pos_x", 32'(pos_x), 9);
        check("exit_pos_y", 32'(pos_y), 5);
        check("at_exit_set", 32'(at_exit), 1);
        run_cmd(CMD_RIGHT, 1'b0, 0, 3'd0, lat);
        check("east_blocked", 32'(blocked), 1);
        check("east_pos_x", 32'(pos_x), 9);

        // UP leaves the exit.
        run_cmd(CMD_UP, 1'b0, 0, 3'd0, lat);
        check("up_pos_y", 32'(pos_y), 4);
        check("up_blocked", 32'(blocked), 0);
        tick();
        check("at_exit_clear", 32'(at_exit), 0);
`ifdef GRID_WALKER_STEPCNT_EN
        check("step_cnt_10", 32'(step_cnt), 10);
`endif

        // Reset in the 10th REVEAL cycle of a LEFT.
        wait_ready(n);
        cmd       = CMD_LEFT;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        dn = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (done) dn++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_pos_x", 32'(pos_x), 0);
        check("midrst_pos_y", 32'(pos_y), 5);
        check("midrst_cmd_ready", 32'(cmd_ready), 0);
`ifdef GRID_WALKER_STEPCNT_EN
        check("midrst_step_cnt", 32'(step_cnt), 0);
`endif
        n = 0;
        while (!cmd_ready && n < 400) begin
            tick();
            n++;
            if (done) dn++;
        end
        check("midrst_no_done", dn, 0);
        check("midrst_ready_after_clear", n, 125);
        rd(53, d, v);
        check("midrst_vis_53", 32'(v), 0);
        rd(84, d, v);
        check("midrst_vis_84", 32'(v), 0);
        rd(50, d, v);
        check("midrst_vis_50", 32'(v), 1);
        rd(51, d, v);
        check("midrst_map_kept", 32'(d), 32'(CELL_BLANK));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_walker.md
GRID_WALKER -- requirements
Module: grid_walker

Interface
REQ-001 The block SHALL take parameter MAP_W, default 10, meaning grid width in cells (2..64).
REQ-002 The block SHALL take parameter MAP_H, default 10, meaning grid height in cells (2..64).
REQ-003 The block SHALL take parameter REVEAL_R, default 2, meaning fog-reveal Manhattan radius (0..7).
REQ-004 The block SHALL take parameters START_X = 0 and START_Y = 5, meaning the reset position (entrance cell).
REQ-005 Derived widths: AW = $clog2(MAP_W*MAP_H), XW = $clog2(MAP_W), YW = $clog2(MAP_H); cell index = y*MAP_W + x.
REQ-006 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-007 Ports SHALL be as follows; all outputs are registered.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd  in  3  0 NOP, 1 RIGHT, 2 LEFT, 3 UP, 4 DOWN; 5-7 treated as NOP
- cmd_ready  out  1  block accepts a command this cycle
- wr_en  in  1  map cell write strobe
- wr_addr  in  AW  map cell index
- wr_data  in  3  cell code
- rd_addr  in  AW  display read index
- rd_data  out  3  cell code at rd_addr; 1-cycle latency
- rd_vis  out  1  revealed bit at rd_addr; 1-cycle latency
- pos_x  out  XW  current column
- pos_y  out  YW  current row
- at_exit  out  1  current cell code is EXIT
- done  out  1  one-cycle pulse when a command completes
- blocked  out  1  one-cycle pulse with done when a move was refused

Function
REQ-008 The FSM SHALL have states CLEAR, IDLE, MOVE and REVEAL.
REQ-009 CLEAR SHALL zero one visible bit per cycle, index 0..MAP_W*MAP_H-1, then go to REVEAL; cmd_ready = 0.
REQ-010 In IDLE, cmd_ready SHALL be 1; a command is accepted on the cycle cmd_valid && cmd_ready.
REQ-011 On acceptance, the FSM SHALL go to MOVE and latch cmd.
- NOP: go straight to REVEAL.
- Target off-grid (x-1 < 0, x+1 >= MAP_W, y-1 < 0, y+1 >= MAP_H): blocked = 1; the grid never wraps.
- Target cell is WALL: blocked = 1.
- Otherwise: pos updates.
REQ-012 After MOVE, the FSM SHALL always go to REVEAL, including blocked moves.
REQ-013 REVEAL SHALL scan the (2R+1)x(2R+1) window centred on pos, one offset per cycle, row-major from (-R,-R).
- It sets the visible bit where the cell is in-grid and |dx|+|dy| <= R.
- It takes exactly (2R+1)^2 cycles.
- On the last cycle it pulses done and returns to IDLE.
REQ-014 Command latency SHALL be 1 + (2R+1)^2 cycles from acceptance to done; 26 for R = 2. cmd_ready is low throughout.
REQ-015 Map writes SHALL be accepted in every state except CLEAR and take effect the next cycle.
REQ-016 The MOVE check SHALL use the pre-write value when a write to the target cell occurs in the same cycle.
REQ-017 rd_data/rd_vis SHALL return the value before any same-cycle write or reveal to that index.
REQ-018 The current cell SHALL always read visible (rd_vis = 1 when rd_addr == pos).
REQ-019 Cell codes SHALL be UNKNOWN 0, CURRENT 1, ENTRANCE 2, EXIT 3, BLANK 4, WALL 5.
REQ-020 at_exit SHALL be updated each cycle from the map code at pos.

Reset
REQ-021 On rst, the block SHALL set state = CLEAR, pos = (START_X, START_Y), cmd_ready = 0, done = 0, blocked = 0 and at_exit = 0.
REQ-022 Map contents SHALL NOT be reset; the map power-up content is BLANK, with ENTRANCE at the start cell and EXIT at (MAP_W-1, START_Y).
REQ-023 Reset asserted mid-MOVE or mid-REVEAL SHALL abandon the command without a done pulse and restart CLEAR.

Configuration
REQ-024 With GRID_WALKER_STEPCNT_EN defined, the block SHALL add output step_cnt (16 bits, reset 0).
- It increments on each non-blocked, non-NOP move.
- It saturates at 0xFFFF.
REQ-025 Without GRID_WALKER_STEPCNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package grid_pkg SHALL hold the cell-code constants, cmd-code constants and the FSM state enum.
REQ-027 Sub-module grid_reveal_scan SHALL generate the dx/dy window counter, the in-radius and in-grid qualifiers, and the last-offset flag.

Verification
REQ-028 The bench SHALL cover the following directed scenarios with defaults (10x10, R = 2):
- Reset, then release: cmd_ready rises after 100 + 25 cycles; cells 30, 40, 41, 50, 51, 52, 60, 61 and 70 read rd_vis = 1; cell 53 reads 0.
- cmd RIGHT from (0,5): done after 26 cycles, pos = (1,5), blocked = 0, cell 53 visible.
- cmd LEFT at (0,5): blocked = 1 with done, pos unchanged.
- Write WALL to index 51, then RIGHT: blocked = 1, pos stays (0,5); a same-cycle write of BLANK to 51 still blocks.
- Nine RIGHT commands: pos = (9,5), at_exit = 1; a tenth RIGHT is blocked with no wrap.
- rst asserted at cycle 10 of REVEAL: no done pulse, pos = (0,5), CLEAR restarts; with GRID_WALKER_STEPCNT_EN, step_cnt = 0.
